// File: rtl/fft_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fft_ctrl_pkg
//  Purpose  : Shared types and size helpers for the radix-2 FFT butterfly sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package fft_ctrl_pkg;

    localparam int STAGE_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int n_of(input int log2n);
        return 1 << log2n;
    endfunction

    function automatic int half_of(input int n);
        return n / 2;
    endfunction

    // Issue-to-write distance: one cycle of sample-RAM read plus the butterfly.
    function automatic int d_of(input int bf_lat);
        return 1 + bf_lat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_bf_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : fft_bf_addr_gen
//  Purpose  : Registered butterfly pair addresses and twiddle index from (s, k).
//  Revision : 1.0  initial release
// ============================================================================
module fft_bf_addr_gen
    import fft_ctrl_pkg::*;
#(
    parameter int LOG2N = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               issue,
    input  logic [STAGE_W-1:0] s,
    input  logic [LOG2N-2:0]   k,
    output logic               rd_en,
    output logic [LOG2N-1:0]   rd_addr_a,
    output logic [LOG2N-1:0]   rd_addr_b,
    output logic [LOG2N-2:0]   tw_idx
);

    logic [LOG2N-2:0] pos_mask;
    logic [LOG2N-2:0] pos;
    logic [LOG2N-1:0] half;
    logic [LOG2N-1:0] base;
    logic [LOG2N-1:0] addr_a;
    logic [LOG2N-2:0] tw;

    // Mask wraps to all-ones in the last stage, where every k is its own position.
    always_comb begin
        pos_mask = ((LOG2N-1)'(1) << s) - (LOG2N-1)'(1);
        pos      = k & pos_mask;
        half     = LOG2N'(1) << s;
        base     = ({1'b0, k} >> s) << (s + STAGE_W'(1));
        addr_a   = base | {1'b0, pos};
        tw       = pos << (STAGE_W'(LOG2N - 1) - s);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_idx    <= '0;
        end else begin
            rd_en     <= issue;
            rd_addr_a <= issue ? addr_a : '0;
            rd_addr_b <= issue ? (addr_a | half) : '0;
            tw_idx    <= issue ? tw : '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fft_bf_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fft_bf_sequencer
//  Purpose  : Stage/butterfly walker for an in-place radix-2 DIT FFT with aligned write-back.
//  Revision : 1.0  initial release
// ============================================================================
module fft_bf_sequencer
    import fft_ctrl_pkg::*;
#(
    parameter int LOG2N  = 4,
    parameter int BF_LAT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [STAGE_W-1:0] stage,
    output logic               rd_en,
    output logic [LOG2N-1:0]   rd_addr_a,
    output logic [LOG2N-1:0]   rd_addr_b,
    output logic [LOG2N-2:0]   tw_idx,
    output logic               wr_en,
    output logic [LOG2N-1:0]   wr_addr_a,
    output logic [LOG2N-1:0]   wr_addr_b
);

    localparam int N      = n_of(LOG2N);
    localparam int HALF_N = half_of(N);
    localparam int D      = d_of(BF_LAT);
    localparam int CNT_W  = $clog2(D + 1);

    localparam logic [LOG2N-2:0]   K_LAST   = (LOG2N-1)'(HALF_N - 1);
    localparam logic [STAGE_W-1:0] S_LAST   = STAGE_W'(LOG2N - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(D - 1);

    state_t             state;
    logic [STAGE_W-1:0] s;
    logic [LOG2N-2:0]   k;
    logic [CNT_W-1:0]   cnt;

    logic               iss;
    logic [STAGE_W-1:0] iss_s;
    logic [LOG2N-2:0]   iss_k;

    // Pair to launch at the coming edge, so addresses register alongside rd_en.
    always_comb begin
        iss   = 1'b0;
        iss_s = s;
        iss_k = k + (LOG2N-1)'(1);
        case (state)
            IDLE: begin
                if (start) begin
                    iss   = 1'b1;
                    iss_s = '0;
                    iss_k = '0;
                end
            end
            RUN: begin
                if (k != K_LAST) begin
                    iss = 1'b1;
                end
            end
            DRAIN: begin
                if (cnt == CNT_LAST && s != S_LAST) begin
                    iss   = 1'b1;
                    iss_s = s + STAGE_W'(1);
                    iss_k = '0;
                end
            end
            default: begin
                iss = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            s     <= '0;
            k     <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        s     <= '0;
                        k     <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (k == K_LAST) begin
                        state <= DRAIN;
                        cnt   <= '0;
                    end else begin
                        k <= iss_k;
                    end
                end
                DRAIN: begin
                    if (cnt == CNT_LAST) begin
                        if (s == S_LAST) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            s     <= '0;
                        end else begin
                            state <= RUN;
                            s     <= iss_s;
                            k     <= '0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign stage = s;

    fft_bf_addr_gen #(
        .LOG2N (LOG2N)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue     (iss),
        .s         (iss_s),
        .k         (iss_k),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_idx    (tw_idx)
    );

    logic [D-1:0]     dly_v;
    logic [LOG2N-1:0] dly_a [D];
    logic [LOG2N-1:0] dly_b [D];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_v <= '0;
            for (int i = 0; i < D; i++) begin
                dly_a[i] <= '0;
                dly_b[i] <= '0;
            end
        end else begin
            dly_v[0] <= rd_en;
            dly_a[0] <= rd_addr_a;
            dly_b[0] <= rd_addr_b;
            for (int i = 1; i < D; i++) begin
                dly_v[i] <= dly_v[i-1];
                dly_a[i] <= dly_a[i-1];
                dly_b[i] <= dly_b[i-1];
            end
        end
    end

    assign wr_en     = dly_v[D-1];
    assign wr_addr_a = dly_a[D-1];
    assign wr_addr_b = dly_b[D-1];

endmodule
`default_nettype wire

// File: doc/fft_bf_sequencer.md
Name: fft_bf_sequencer

Overview:
- Control block for an in-place radix-2 DIT FFT built around the shared 16-bit complex butterfly (complex add/sub with 1/2 scaling per stage).
- Walks all LOG2N stages. For each stage it issues one butterfly pair per cycle: read addresses A/B and a twiddle index.
- Produces write-back addresses and strobes, aligned to the datapath latency.
- Reports busy/done to the host.

Parameters:
- LOG2N, 4, log2 of FFT length N (N = 2**LOG2N); legal range 2..15.
- BF_LAT, 2, butterfly datapath latency in cycles, from read data valid to result valid.
- (derived) D = 1 + BF_LAT: issue-to-write delay. 1 cycle is sample-RAM read latency.

Ports:
- clk, in, 1, system clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, begin a transform. Sampled only in IDLE.
- busy, out, 1, high from the cycle after start is accepted until done.
- done, out, 1, one-cycle pulse when the last write of the last stage has been issued.
- stage, out, 4, current stage index 0..LOG2N-1. 0 when idle.
- rd_en, out, 1, read strobe for the butterfly pair.
- rd_addr_a, out, LOG2N, upper-wing sample address.
- rd_addr_b, out, LOG2N, lower-wing sample address.
- tw_idx, out, LOG2N-1, twiddle ROM index, valid with rd_en.
- wr_en, out, 1, write-back strobe.
- wr_addr_a, out, LOG2N, write address for the A result.
- wr_addr_b, out, LOG2N, write address for the B result.

Behaviour:
- Reset: FSM to IDLE, all outputs 0, delay-line valid bits cleared. No spurious wr_en after reset release, including when reset is asserted mid-run.
- FSM states:
  - IDLE: start=1 -> RUN with s=0, k=0.
  - RUN: rd_en=1 every cycle, k increments. After k = N/2-1 -> DRAIN.
  - DRAIN: wait D cycles. Reads are held off so stage s+1 never reads data that stage s has not yet written. Then, if s < LOG2N-1: s++, k=0, -> RUN. Otherwise -> DONE.
  - DONE: done=1 for one cycle, busy=0, -> IDLE.
- start while busy is ignored. start in the DONE cycle is ignored. start in the first IDLE cycle after DONE is accepted.
- Address generation for butterfly k in stage s, with half = 2**s:
  - pos = k mod half; grp = k div half.
  - rd_addr_a = grp*2*half + pos.
  - rd_addr_b = rd_addr_a + half.
  - tw_idx = pos << (LOG2N-1-s).
  - All computed with shifts and masks only, no multipliers. Outputs are registered and valid in the same cycle as rd_en.
- Write path:
  - wr_en, wr_addr_a and wr_addr_b are rd_en, rd_addr_a and rd_addr_b delayed exactly D cycles.
  - Implemented as a shift register with valid bit.
  - The last write of each stage falls in that stage's final DRAIN cycle.
- Timing: start is sampled at edge 0.
  - First rd_en in cycle 1; first wr_en in cycle 1+D.
  - done asserts in cycle LOG2N*(N/2+D)+1. For defaults this is cycle 45.
- stage output updates on the first RUN cycle of each stage and holds through that stage's DRAIN.
- Arithmetic:
  - k counter is LOG2N-1 bits and wraps only under FSM control.
  - The drain counter is sized for D.
  - No overflow is possible within legal parameters.

Decomposition:
- Package fft_ctrl_pkg:
  - FSM state enum (IDLE, RUN, DRAIN, DONE).
  - localparams N, HALF_N, D.
  - Stage-width constant.
- Sub-module fft_bf_addr_gen: registered pair-address and twiddle calculation from (s, k).
- The D-deep write-address delay line stays inline in the top module.

Test Plan (defaults LOG2N=4, BF_LAT=2):
- Reset: hold rst_n=0 over several clk edges -> every output 0; after release with start=0, outputs stay 0 and busy=0.
- Stage 0/1 addresses: pulse start -> stage 0 pairs (0,1),(2,3)..(14,15) with tw_idx all 0; stage 1 pairs (0,2),(1,3),(4,6),(5,7)... with tw_idx 0,4,0,4...
- Stage 3 addresses: stage 3 pairs (0,8)..(7,15) with tw_idx 0..7.
- Timing: rd_en first high in cycle 1; wr_en first high in cycle 4 with wr_addr (0,1); 8 rd_en cycles per stage followed by a 3-cycle gap; done pulses once in cycle 45; busy falls in the same cycle.
- Start while busy: pulse start at cycles 10 and 30 during a run -> no effect on sequence or timing. Start pulsed in the DONE cycle -> ignored. Start in the next cycle -> a new run begins.
- Reset mid-run: assert rst_n=0 at cycle 20, release, then start -> no wr_en before the new run's cycle 4; full correct 45-cycle sequence.
- Parameter sweep: LOG2N=2, BF_LAT=0 -> pairs (0,1),(2,3) then (0,2),(1,3) with tw_idx 0,1; done at cycle 2*(2+1)+1 = 7.
